uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Two-requester write arbiter for the UART transmit FIFO. It shares the FIFO's single write port between two byte sources, for example the CPU MMIO path and a debug/trace source. Each source is granted the port for a burst: the burst ends on a last-byte marker or after a configurable beat cap. Grants alternate round-robin so neither source can starve the other. The block sits between the sources and the FIFO's `wr`/`w_data`/`full` pins.

## Interface
- `B`, default 8: data width in bits; must match the FIFO data width.
- `MAXBURST`, default 4: maximum number of writes per grant; legal range 1..16.

- `clk`  in  1  system clock; all state updates on the falling edge, matching the FIFO.
- `reset`  in  1  asynchronous, active-high reset.
- `req0`, `req1`  in  1 each  requester n has a byte to write.
- `data0`, `data1`  in  B each  requester n byte; must be held stable while `reqn` is high and `ackn` is low.
- `last0`, `last1`  in  1 each  current byte of requester n ends its burst.
- `ack0`, `ack1`  out  1 each  byte accepted on this edge; requester presents its next byte after the edge.
- `fifo_full`  in  1  FIFO full flag.
- `fifo_wr`  out  1  FIFO write strobe.
- `fifo_w_data`  out  B  FIFO write data.
- `grant`  out  2  one-hot current owner; `2'b00` when idle.
- `busy`  out  1  `|grant`.

## Operation
- **State machine states**
  - IDLE: no owner.
  - G0: requester 0 owns the port.
  - G1: requester 1 owns the port.
- **Priority pointer `prio`** (1 bit) selects the preferred requester when both request.
  - Reset value 0.
  - After any release, `prio` is set to the other requester.
- **IDLE**
  - Only `req0`: go to G0.
  - Only `req1`: go to G1.
  - Both: go to G`prio`.
  - Neither: stay in IDLE.
- **Gn datapath (combinational)**
  - `fifo_w_data = datan`.
  - `fifo_wr = ackn = reqn & ~fifo_full`.
  - The other ack is 0.
  - In IDLE, `fifo_wr = 0`, both acks are 0, and `fifo_w_data = 0`.
- **Beat counter `cnt`** (4 bits)
  - Cleared on every grant entry.
  - Incremented on every write in Gn.
- **Release conditions in Gn** (any one of)
  - A write with `lastn = 1`.
  - A write with `cnt == MAXBURST-1`.
  - `reqn = 0` for a cycle.
- **On release**
  - If the other requester is requesting, go directly to G(other) with no idle cycle.
  - Otherwise go to IDLE.
- **Full stall**
  - While `fifo_full = 1` in Gn, `fifo_wr` and `ackn` are 0.
  - The grant and `cnt` are held.
  - There is no timeout.
- **Reset, including mid-burst**
  - State goes to IDLE, `prio` to 0, `cnt` to 0.
  - Bytes not yet acked are not written.
- **Reset values of outputs**
  - `grant = 00`, `busy = 0`, `fifo_wr = 0`, `ack0 = ack1 = 0`, `fifo_w_data = 0`.

## Timing
- Grant latency: `req` rising while IDLE gives `grant` on the next falling edge. The first `fifo_wr` is in the cycle following that edge.
- Write commit: the FIFO latches `fifo_w_data` on the same falling edge where `fifo_wr`/`ackn` are high.
- Sustained throughput: 1 byte per cycle while the grant is held and the FIFO is not full.
- Handover: the last write of requester n and the first write of requester m are in consecutive cycles, with zero bubbles.
- Burst cap boundary:
  - `MAXBURST = 1` gives alternating single-byte grants when both requesters are active.
  - `cnt` never exceeds `MAXBURST-1`.
- Full and release together: the final byte waits for `fifo_full = 0` before it is written. The release occurs on that write's edge.
- Request drop: a requester that drops `req` while stalled by `fifo_full` loses the grant at the next edge.

## Test plan
- **Single-requester burst after reset:** `req0 = 1`, data A1..A3, `last0` on A3 → `grant = 01` after 1 edge; `fifo_wr` for 3 consecutive cycles with A1, A2, A3; then IDLE, `prio = 1`.
- **Contention with cap:** `MAXBURST = 4`, both requesters stream with no `last` → FIFO order is 4 bytes from req0, 4 from req1, 4 from req0; zero-cycle gaps at each handover.
- **Full stall:** `fifo_full` asserted for 5 cycles mid-burst of req1 → `fifo_wr = ack1 = 0` for those 5 cycles; `grant` stays `10`; the burst resumes with the same byte and `cnt` unchanged.
- **Request drop:** req0 granted, `req0` deasserted after 2 bytes while `req1 = 1` → next edge gives `grant = 10`; exactly 2 req0 bytes were written.
- **Reset mid-burst:** `reset` pulsed asynchronously during the 3rd byte of a req0 burst → outputs go immediately to `grant = 00`, `fifo_wr = 0`, acks 0. After release, with both requesting, req0 wins because `prio = 0`.
- **MAXBURST = 1 fairness:** both requesters continuous for 10 writes → exactly 5 bytes each, strictly alternating, starting with req0.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester/FIFO signal bundle for uart_tx_arbiter
// Purpose: carries both requester handshakes and the UART TX FIFO write port.
// Signals:
//   req0/req1, data0/data1, last0/last1 : requester byte offers and burst markers
//   ack0/ack1                           : byte accepted on this falling edge
//   fifo_full                           : FIFO full flag
//   fifo_wr, fifo_w_data                : FIFO write strobe and data
//   grant, busy                         : one-hot current owner, |grant
// Modports: master = sources plus FIFO side, slave = the arbiter.
`timescale 1ns/1ps
interface uart_tx_arbiter_if #(
  parameter int B = 8
);
  logic         req0;
  logic         req1;
  logic [B-1:0] data0;
  logic [B-1:0] data1;
  logic         last0;
  logic         last1;
  logic         ack0;
  logic         ack1;
  logic         fifo_full;
  logic         fifo_wr;
  logic [B-1:0] fifo_w_data;
  logic [1:0]   grant;
  logic         busy;

  modport master (
    output req0, req1, data0, data1, last0, last1, fifo_full,
    input  ack0, ack1, fifo_wr, fifo_w_data, grant, busy
  );

  modport slave (
    input  req0, req1, data0, data1, last0, last1, fifo_full,
    output ack0, ack1, fifo_wr, fifo_w_data, grant, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - two-requester round-robin burst arbiter for the UART TX FIFO write port
// Purpose: grants the FIFO write port to one requester at a time for a burst that
//   ends on last, on the MAXBURST beat cap, or when the owner drops req.
// Ports:
//   clk   : clock, state updates on the falling edge (same edge as the FIFO)
//   reset : asynchronous active-high reset
//   bus   : uart_tx_arbiter_if.slave (requesters, acks, FIFO port, grant/busy)
// Parameters: B data width, MAXBURST beats per grant (1..16).
`timescale 1ns/1ps
module uart_tx_arbiter #(
  parameter int B        = 8,
  parameter int MAXBURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(MAXBURST - 1);

  state_t       state_q;
  logic         prio_q;
  logic [3:0]   cnt_q;
  logic [1:0]   grant_q;

  logic         wr0;
  logic         wr1;
  logic         rel0;
  logic         rel1;
  logic [B-1:0] w_data_d;

  // Writes are combinational so a byte commits on the same edge it is acked;
  // a full FIFO simply withholds the strobe, leaving grant and cnt untouched.
  always_comb begin
    wr0  = (state_q == G0) & bus.req0 & ~bus.fifo_full;
    wr1  = (state_q == G1) & bus.req1 & ~bus.fifo_full;
    // Owner gives up the port when it stops requesting, or on a write that is
    // either marked last or the final beat allowed by the cap.
    rel0 = ~bus.req0 | (wr0 & (bus.last0 | (cnt_q == CNT_LAST)));
    rel1 = ~bus.req1 | (wr1 & (bus.last1 | (cnt_q == CNT_LAST)));
  end

  always_comb begin
    w_data_d = '0;
    case (state_q)
      G0:      w_data_d = bus.data0;
      G1:      w_data_d = bus.data1;
      default: w_data_d = '0;
    endcase
  end

  assign bus.ack0        = wr0;
  assign bus.ack1        = wr1;
  assign bus.fifo_wr     = wr0 | wr1;
  assign bus.fifo_w_data = w_data_d;
  assign bus.grant       = grant_q;
  assign bus.busy        = |grant_q;

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      cnt_q   <= 4'd0;
      grant_q <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= 4'd0;
          if (bus.req0 & (~bus.req1 | ~prio_q)) begin
            state_q <= G0;
            grant_q <= 2'b01;
          end else if (bus.req1) begin
            state_q <= G1;
            grant_q <= 2'b10;
          end
        end
        G0: begin
          if (rel0) begin
            // Hand straight to the other side when it is waiting: no idle bubble.
            prio_q <= 1'b1;
            cnt_q  <= 4'd0;
            if (bus.req1) begin
              state_q <= G1;
              grant_q <= 2'b10;
            end else begin
              state_q <= IDLE;
              grant_q <= 2'b00;
            end
          end else if (wr0) begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        G1: begin
          if (rel1) begin
            prio_q <= 1'b0;
            cnt_q  <= 4'd0;
            if (bus.req0) begin
              state_q <= G0;
              grant_q <= 2'b01;
            end else begin
              state_q <= IDLE;
              grant_q <= 2'b00;
            end
          end else if (wr1) begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= 2'b00;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized model-checked bench for uart_tx_arbiter
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int B     = 8;
  localparam int CAP_A = 4;

  logic clk = 1'b1;
  logic reset;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.B(B)) ifa ();
  uart_tx_arbiter_if #(.B(B)) ifb ();

  uart_tx_arbiter #(.B(B), .MAXBURST(CAP_A)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  uart_tx_arbiter #(.B(B), .MAXBURST(1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Source-side stimulus state for dut_a.
  bit         s_req  [2];
  logic [7:0] s_data [2];
  bit         s_last [2];
  bit         s_full;

  // Reference model: who owns the port, who is preferred, beats in this burst.
  int m_owner;
  bit m_prio;
  int m_beats;
  bit m_acked [2];
  int m_writes [2];

  task automatic drive_a();
    ifa.req0      = s_req[0];
    ifa.req1      = s_req[1];
    ifa.data0     = s_data[0];
    ifa.data1     = s_data[1];
    ifa.last0     = s_last[0];
    ifa.last1     = s_last[1];
    ifa.fifo_full = s_full;
  endtask

  // One cycle on dut_a: compare outputs at the rising edge (mid-cycle), advance
  // the model to what the coming falling edge should do, return at negedge+1.
  task automatic tick_a();
    bit         e_ack [2];
    logic [7:0] e_data;
    logic [1:0] e_grant;
    int         n;
    int         o;
    bit         rel;
    @(posedge clk);
    e_grant  = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
    e_ack[0] = (m_owner == 0) && s_req[0] && !s_full;
    e_ack[1] = (m_owner == 1) && s_req[1] && !s_full;
    e_data   = (m_owner < 0) ? 8'h00 : s_data[m_owner];
    check("grant",   32'(ifa.grant),       32'(e_grant));
    check("busy",    32'(ifa.busy),        32'(e_grant != 2'b00));
    check("fifo_wr", 32'(ifa.fifo_wr),     32'(e_ack[0] | e_ack[1]));
    check("ack0",    32'(ifa.ack0),        32'(e_ack[0]));
    check("ack1",    32'(ifa.ack1),        32'(e_ack[1]));
    check("w_data",  32'(ifa.fifo_w_data), 32'(e_data));
    if (m_owner < 0) begin
      if (s_req[0] && s_req[1]) m_owner = int'(m_prio);
      else if (s_req[0])        m_owner = 0;
      else if (s_req[1])        m_owner = 1;
      m_beats = 0;
    end else begin
      n   = m_owner;
      o   = 1 - n;
      rel = !s_req[n] || (e_ack[n] && (s_last[n] || (m_beats + 1 == CAP_A)));
      if (e_ack[n]) begin
        m_beats++;
        m_writes[n]++;
      end
      if (rel) begin
        m_prio  = (o == 1);
        m_owner = s_req[o] ? o : -1;
        m_beats = 0;
      end
    end
    m_acked[0] = e_ack[0];
    m_acked[1] = e_ack[1];
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"},   32'(ifa.grant),       32'(0));
    check({tag, "_busy"},    32'(ifa.busy),        32'(0));
    check({tag, "_fifo_wr"}, 32'(ifa.fifo_wr),     32'(0));
    check({tag, "_ack0"},    32'(ifa.ack0),        32'(0));
    check({tag, "_ack1"},    32'(ifa.ack1),        32'(0));
    check({tag, "_w_data"},  32'(ifa.fifo_w_data), 32'(0));
  endtask

  initial begin
    logic [7:0] burst [3];
    int         idx;
    int         n0;
    int         n1;
    logic [7:0] b_exp;

    burst[0] = 8'hA1;
    burst[1] = 8'hA2;
    burst[2] = 8'hA3;

    reset = 1'b1;
    for (int n = 0; n < 2; n++) begin
      s_req[n]    = 1'b0;
      s_data[n]   = 8'h00;
      s_last[n]   = 1'b0;
      m_writes[n] = 0;
    end
    s_full  = 1'b0;
    drive_a();
    ifb.req0 = 1'b0; ifb.req1 = 1'b0; ifb.data0 = 8'h00; ifb.data1 = 8'h00;
    ifb.last0 = 1'b0; ifb.last1 = 1'b0; ifb.fifo_full = 1'b0;
    m_owner = -1;
    m_prio  = 1'b0;
    m_beats = 0;

    #1;
    check_reset_outputs("por");
    @(negedge clk);
    #1;
    reset = 1'b0;

    // Single req0 burst A1..A3 ending on last.
    idx       = 0;
    s_req[0]  = 1'b1;
    s_data[0] = burst[0];
    s_last[0] = 1'b0;
    drive_a();
    for (int c = 0; c < 12 && idx < 3; c++) begin
      tick_a();
      if (m_acked[0]) begin
        idx++;
        if (idx < 3) begin
          s_data[0] = burst[idx];
          s_last[0] = (idx == 2);
        end else begin
          s_req[0]  = 1'b0;
          s_last[0] = 1'b0;
        end
        drive_a();
      end
    end
    check("burst_bytes", 32'(idx), 32'(3));
    tick_a();

    // req0 alone streams; reset lands asynchronously during its 3rd byte.
    s_req[0] = 1'b1;
    n0 = 0;
    drive_a();
    for (int c = 0; c < 12 && n0 < 2; c++) begin
      tick_a();
      if (m_acked[0]) begin
        n0++;
        s_data[0] = 8'($urandom);
        drive_a();
      end
    end
    check("pre_reset_bytes", 32'(n0), 32'(2));
    check("third_byte_live", 32'(ifa.fifo_wr), 32'(1));
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("mid");
    m_owner = -1;
    m_prio  = 1'b0;
    m_beats = 0;
    @(negedge clk);
    #1;
    reset = 1'b0;

    // Both request after reset: model expects req0 to win (prio back to 0).
    s_req[1]  = 1'b1;
    s_data[1] = 8'h5B;
    drive_a();
    tick_a();
    tick_a();
    check("post_reset_winner", 32'(ifa.grant), 32'(2'b01));

    // Randomized traffic: contention, last markers, full stalls, request drops.
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (m_acked[n] || !s_req[n]) begin
          if ($urandom_range(0, 3) != 0) begin
            s_req[n]  = 1'b1;
            s_data[n] = 8'($urandom);
            s_last[n] = ($urandom_range(0, 4) == 0);
          end else begin
            s_req[n] = 1'b0;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          s_req[n] = 1'b0;
        end
      end
      s_full = ($urandom_range(0, 5) == 0);
      drive_a();
      tick_a();
    end

    // MAXBURST = 1: two continuous requesters alternate one byte each, req0 first.
    ifb.req0  = 1'b1;
    ifb.req1  = 1'b1;
    ifb.data0 = 8'hA0;
    ifb.data1 = 8'hB1;
    @(posedge clk);
    check("b_idle_grant", 32'(ifb.grant), 32'(0));
    @(negedge clk);
    #1;
    n0 = 0;
    n1 = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      b_exp = ((k % 2) == 0) ? 8'hA0 : 8'hB1;
      check("b_wr",  32'(ifb.fifo_wr),     32'(1));
      check("b_src", 32'(ifb.fifo_w_data), 32'(b_exp));
      if (ifb.ack0) n0++;
      if (ifb.ack1) n1++;
      @(negedge clk);
      #1;
    end
    check("b_count0", 32'(n0), 32'(5));
    check("b_count1", 32'(n1), 32'(5));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
